mips_cpu_bus: RTL and testbench
===============================

Name: mips_cpu_bus

Overview:
- Multicycle MIPS-I subset CPU (little-endian) with a single Avalon-style memory-mapped master port shared by instruction fetch and data access.
- Starts at reset vector 0xBFC00000 and runs until execution reaches address 0x00000000, then halts and drops `active`.
- `register_v0` exposes $2 for test observation.
- Sits at the top of the CPU test harness, connected directly to a bus RAM model.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- active  output  1  high while CPU runs; low once halted
- register_v0  output  32  current value of GPR $2, combinational from the register file
- address  output  32  byte address, always word-aligned (bits[1:0]=0)
- write  output  1  write request
- read  output  1  read request
- waitrequest  input  1  slave stall; hold request and all bus outputs while high
- writedata  output  32  store data
- byteenable  output  4  byte lanes; bit0 = writedata[7:0]
- readdata  input  32  read data; valid the first clk edge after read accepted (read high, waitrequest low)

Behaviour:
- Reset (async, reset=0):
  - PC=RESET_VECTOR; all 32 GPRs=0; delay-slot state cleared; state=FETCH.
  - read=write=0, byteenable=0, writedata=0, active=1.
- States:
  - FETCH: read=1, address=PC, byteenable=4'b1111. Hold while waitrequest. If PC==0, go to HALT instead of issuing the read.
  - EXEC: latch readdata as instruction, decode, read rs/rt, run ALU, resolve branch/jump, write back ALU results. Loads/stores go to MEM; all other instructions go to FETCH.
  - MEM: read or write at rs+sext(imm), held while waitrequest. Stores go to FETCH. Loads go to WB.
  - WB: write readdata to rt, then FETCH.
  - HALT: read=write=0, active=0. Terminal state until reset.
- Never assert read and write together.
- $0 reads as 0; writes to $0 are ignored.
- Instruction subset:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR.
  - I-type: ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW.
  - Branches: BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL.
  - Jumps: J, JAL.
- Immediates: logical ops (ANDI/ORI/XORI) zero-extend; all others sign-extend. ADDIU/ADDU never trap; overflow wraps mod 2^32.
- Branch delay slots:
  - Every branch/jump executes the next sequential instruction before the target.
  - Branch target = PC_of_branch + 4 + (sext(imm)<<2).
  - J/JAL target = {PC+4[31:28], idx, 2'b00}.
  - Links write PC_of_branch+8 to $31 (JALR: to rd).
  - Link register write happens even if the branch is not taken.
- Branch/jump in a delay slot: undefined, no special handling.
- Comparisons for BLTZ/BGEZ/BLEZ/BGTZ are signed, on rs.
- SW: byteenable=4'b1111.
- Unknown opcodes execute as NOP.
- Halt sequence: JR $0 plus its delay slot, then the next fetch sees PC==0 → HALT. The delay-slot result is committed before halting.

Optional Feature:
- Macro MIPS_CPU_SUBWORD_EN. When defined, adds LB, LBU, LH, LHU, SB, SH:
  - Address aligned down to the word.
  - Store byteenable: one bit (SB) or 2'b11 pair (SH) selected by addr[1:0]; writedata lane-replicated.
  - Loads extract the lane from readdata and sign- or zero-extend.
- When undefined, these opcodes are NOPs.

Test Plan:
- BLTZ not-taken:
  - Program: LUI $8,0xBFC0; LW $9,0x2C($8) (word=0); BLTZ $9 to a block with LUI $2,0xFFFF; fall-through JR $0.
  - Expected: halt with active=0, register_v0=0x00000000.
- BLTZ taken: same program with the data word = 0xFFFFFFF1 → register_v0=0xFFFF0000.
- Reset and startup:
  - Hold reset low 2 cycles, then release.
  - Expected: first bus read at 0xBFC00000, active=1 within one cycle.
- Waitrequest stall:
  - Assert waitrequest for 5 cycles during a fetch.
  - Expected: address/read stable throughout; same final v0 as without stalls.
- Store/load round-trip:
  - ADDIU $3,$0,15; SW $3 to a RAM word; LW $2 back; JR $0.
  - Expected: byteenable=4'b1111 on the write, register_v0=15.
- JAL link: JAL to a subroutine that does ADDU $2,$31,$0 then JR $0 → register_v0=JAL_address+8.

Source files
------------

// File: rtl/mips_cpu_bus.sv
// mips_cpu_bus: multicycle little-endian MIPS-I subset CPU with a single
// Avalon-style master port shared by instruction fetch and data access.
// Optional sub-word loads/stores (LB/LBU/LH/LHU/SB/SH) are built in when the
// macro MIPS_CPU_SUBWORD_EN is defined; otherwise those opcodes are NOPs.
//
// state | meaning
// FETCH | read instruction at pc (or halt when pc is zero)
// EXEC  | decode readdata, ALU, branch/jump resolution, register write-back
// MEM   | data read/write at rs+sext(imm)
// WB    | load data written into rt
// HALT  | stopped, active low, until reset
module mips_cpu_bus #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);
  typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_nx;

  // pc is the instruction being fetched; npc is its successor, which carries
  // the branch target across the delay slot.
  logic [31:0] pc, npc;
  logic [31:0] gpr [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, sext, zext, eff_addr, pc_plus4, link, br_tgt, j_tgt;

  logic        wb_en, taken, is_load, is_store;
  logic [4:0]  wb_idx;
  logic [31:0] wb_val, tgt, st_data_c, ld_val;
  logic [3:0]  st_be_c;

  logic [29:0] mem_word;
  logic        mem_store;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [4:0]  ld_rt;
`ifdef MIPS_CPU_SUBWORD_EN
  logic [1:0]  sz_c, ld_size, ld_off;
  logic        sgn_c, ld_sign;
  logic [7:0]  byte_l;
  logic [15:0] half_l;
`else
  logic        addr_lo_unused;
  assign addr_lo_unused = ^eff_addr[1:0];
`endif

  assign op       = readdata[31:26];
  assign rs       = readdata[25:21];
  assign rt       = readdata[20:16];
  assign rd       = readdata[15:11];
  assign shamt    = readdata[10:6];
  assign funct    = readdata[5:0];
  assign imm      = readdata[15:0];
  assign sext     = {{16{imm[15]}}, imm};
  assign zext     = {16'h0000, imm};
  assign rs_val   = gpr[rs];
  assign rt_val   = gpr[rt];
  assign eff_addr = rs_val + sext;
  assign pc_plus4 = pc + 32'd4;
  assign link     = pc + 32'd8;
  assign br_tgt   = pc_plus4 + {sext[29:0], 2'b00};
  assign j_tgt    = {pc_plus4[31:28], readdata[25:0], 2'b00};

  assign register_v0 = gpr[2];
  assign active      = (state != HALT);

  // Instruction decode and execute for the word currently on readdata
  always_comb begin
    wb_en    = 1'b0;
    wb_idx   = rd;
    wb_val   = '0;
    taken    = 1'b0;
    tgt      = br_tgt;
    is_load  = 1'b0;
    is_store = 1'b0;
`ifdef MIPS_CPU_SUBWORD_EN
    sz_c  = 2'd2;
    sgn_c = 1'b0;
`endif
    case (op)
      6'h00: begin
        wb_en = 1'b1;
        case (funct)
          6'h21: wb_val = rs_val + rt_val;
          6'h23: wb_val = rs_val - rt_val;
          6'h24: wb_val = rs_val & rt_val;
          6'h25: wb_val = rs_val | rt_val;
          6'h26: wb_val = rs_val ^ rt_val;
          6'h27: wb_val = ~(rs_val | rt_val);
          6'h2A: wb_val = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: wb_val = {31'd0, rs_val < rt_val};
          6'h00: wb_val = rt_val << shamt;
          6'h02: wb_val = rt_val >> shamt;
          6'h03: wb_val = $unsigned($signed(rt_val) >>> shamt);
          6'h04: wb_val = rt_val << rs_val[4:0];
          6'h06: wb_val = rt_val >> rs_val[4:0];
          6'h07: wb_val = $unsigned($signed(rt_val) >>> rs_val[4:0]);
          6'h08: begin wb_en = 1'b0; taken = 1'b1; tgt = rs_val; end
          6'h09: begin taken = 1'b1; tgt = rs_val; wb_val = link; end
          default: wb_en = 1'b0;
        endcase
      end
      6'h01: if (rt == 5'h00 || rt == 5'h01 || rt == 5'h10 || rt == 5'h11) begin
        taken  = rt[0] ? ~rs_val[31] : rs_val[31];
        wb_en  = rt[4];
        wb_idx = 5'd31;
        wb_val = link;
      end
      6'h02: begin taken = 1'b1; tgt = j_tgt; end
      6'h03: begin taken = 1'b1; tgt = j_tgt; wb_en = 1'b1; wb_idx = 5'd31; wb_val = link; end
      6'h04: taken = (rs_val == rt_val);
      6'h05: taken = (rs_val != rt_val);
      6'h06: taken = rs_val[31] | (rs_val == 32'd0);
      6'h07: taken = ~rs_val[31] & (rs_val != 32'd0);
      6'h09: begin wb_en = 1'b1; wb_idx = rt; wb_val = rs_val + sext; end
      6'h0A: begin wb_en = 1'b1; wb_idx = rt; wb_val = {31'd0, $signed(rs_val) < $signed(sext)}; end
      6'h0B: begin wb_en = 1'b1; wb_idx = rt; wb_val = {31'd0, rs_val < sext}; end
      6'h0C: begin wb_en = 1'b1; wb_idx = rt; wb_val = rs_val & zext; end
      6'h0D: begin wb_en = 1'b1; wb_idx = rt; wb_val = rs_val | zext; end
      6'h0E: begin wb_en = 1'b1; wb_idx = rt; wb_val = rs_val ^ zext; end
      6'h0F: begin wb_en = 1'b1; wb_idx = rt; wb_val = {imm, 16'h0000}; end
      6'h23: is_load = 1'b1;
      6'h2B: is_store = 1'b1;
`ifdef MIPS_CPU_SUBWORD_EN
      6'h20: begin is_load = 1'b1; sz_c = 2'd0; sgn_c = 1'b1; end
      6'h24: begin is_load = 1'b1; sz_c = 2'd0; end
      6'h21: begin is_load = 1'b1; sz_c = 2'd1; sgn_c = 1'b1; end
      6'h25: begin is_load = 1'b1; sz_c = 2'd1; end
      6'h28: begin is_store = 1'b1; sz_c = 2'd0; end
      6'h29: begin is_store = 1'b1; sz_c = 2'd1; end
`endif
      default: ;
    endcase
  end

  // Store lane select and data replication
  always_comb begin
    st_be_c   = 4'b1111;
    st_data_c = rt_val;
`ifdef MIPS_CPU_SUBWORD_EN
    if (sz_c == 2'd0) begin
      st_be_c   = 4'b0001 << eff_addr[1:0];
      st_data_c = {4{rt_val[7:0]}};
    end else if (sz_c == 2'd1) begin
      st_be_c   = eff_addr[1] ? 4'b1100 : 4'b0011;
      st_data_c = {2{rt_val[15:0]}};
    end
`endif
  end

  // Load lane extraction and extension
  always_comb begin
    ld_val = readdata;
`ifdef MIPS_CPU_SUBWORD_EN
    byte_l = readdata[{ld_off, 3'b000} +: 8];
    half_l = ld_off[1] ? readdata[31:16] : readdata[15:0];
    case (ld_size)
      2'd0:    ld_val = {{24{ld_sign & byte_l[7]}}, byte_l};
      2'd1:    ld_val = {{16{ld_sign & half_l[15]}}, half_l};
      default: ;
    endcase
`endif
  end

  // Next state and bus outputs; bus is idle while reset is held
  always_comb begin
    state_nx   = state;
    read       = 1'b0;
    write      = 1'b0;
    address    = pc;
    byteenable = 4'b0000;
    writedata  = '0;
    case (state)
      FETCH: begin
        if (pc == 32'd0) state_nx = HALT;
        else begin
          read       = 1'b1;
          byteenable = 4'b1111;
          if (!waitrequest) state_nx = EXEC;
        end
      end
      EXEC: state_nx = (is_load || is_store) ? MEM : FETCH;
      MEM: begin
        address = {mem_word, 2'b00};
        if (mem_store) begin
          write      = 1'b1;
          byteenable = st_be;
          writedata  = st_data;
        end else begin
          read       = 1'b1;
          byteenable = 4'b1111;
        end
        if (!waitrequest) state_nx = mem_store ? FETCH : WB;
      end
      WB:      state_nx = FETCH;
      default: state_nx = HALT;
    endcase
    if (!reset) begin
      read       = 1'b0;
      write      = 1'b0;
      byteenable = 4'b0000;
      writedata  = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nx;
  end

  // Program counter, delay-slot successor and latched memory-op context
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_VECTOR;
      npc       <= RESET_VECTOR + 32'd4;
      mem_word  <= '0;
      mem_store <= 1'b0;
      st_be     <= 4'b0000;
      st_data   <= '0;
      ld_rt     <= '0;
`ifdef MIPS_CPU_SUBWORD_EN
      ld_size   <= 2'd2;
      ld_sign   <= 1'b0;
      ld_off    <= 2'd0;
`endif
    end else if (state == EXEC) begin
      pc  <= npc;
      npc <= taken ? tgt : npc + 32'd4;
      if (is_load || is_store) begin
        mem_word  <= eff_addr[31:2];
        mem_store <= is_store;
        st_be     <= st_be_c;
        st_data   <= st_data_c;
        ld_rt     <= rt;
`ifdef MIPS_CPU_SUBWORD_EN
        ld_size   <= sz_c;
        ld_sign   <= sgn_c;
        ld_off    <= eff_addr[1:0];
`endif
      end
    end
  end

  // Register file; $0 is never written so it always reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (state == EXEC && wb_en && wb_idx != 5'd0) begin
      gpr[wb_idx] <= wb_val;
    end else if (state == WB && ld_rt != 5'd0) begin
      gpr[ld_rt] <= ld_val;
    end
  end
endmodule

// File: tb/tb_mips_cpu_bus.sv
// Bench for mips_cpu_bus: bus RAM model, directed programs, scoreboard of
// expected stores and final $v0 values.
module tb_mips_cpu_bus;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = '0;

  always #5 clk = ~clk;

  mips_cpu_bus #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic [31:0] rom [64];
  logic [31:0] ram [64];
  logic [31:0] exp_v0_q [$];
  wr_t         exp_wr_q [$];
  int          tests = 0;
  int          fails = 0;
  int          stall_len = 0;
  int          stall_seen = 0;
  logic [31:0] stall_addr = '0;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] JR0 = 32'h0000_0008;

  function automatic logic [31:0] ity(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rty(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a[31:16] == 16'hBFC0) return rom[a[7:2]];
    return ram[a[7:2]];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      rom[i] = '0;
      ram[i] = '0;
    end
  endtask

  task automatic exp_store(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.be   = 4'b1111;
    exp_wr_q.push_back(w);
  endtask

  task automatic apply_reset(input bit check_outputs);
    @(negedge clk);
    reset       = 1'b0;
    readdata    = '0;
    waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    if (check_outputs) begin
      check("rst_read", {31'd0, read}, 32'd0);
      check("rst_write", {31'd0, write}, 32'd0);
      check("rst_active", {31'd0, active}, 32'd1);
      check("rst_byteenable", {28'd0, byteenable}, 32'd0);
      check("rst_writedata", writedata, 32'd0);
    end
    reset = 1'b1;
    #1;
    if (check_outputs) begin
      check("start_read", {31'd0, read}, 32'd1);
      check("start_address", address, 32'hBFC00000);
      check("start_byteenable", {28'd0, byteenable}, 32'hF);
      check("start_active", {31'd0, active}, 32'd1);
    end
  endtask

  // Cycle loop acting as the bus RAM; runs until the CPU halts or the budget expires
  task automatic run_prog(input int max_cycles);
    bit          halted;
    bit          rd_pending;
    bit          stall_on;
    bit          overlap;
    int          stall_left;
    logic [31:0] rd_data;
    wr_t         w;
    halted = 1'b0; rd_pending = 1'b0; stall_on = 1'b0; overlap = 1'b0;
    stall_left = stall_len; rd_data = '0; stall_seen = 0;
    for (int cyc = 0; cyc < max_cycles && !halted; cyc++) begin
      if (rd_pending) begin
        readdata   = rd_data;
        rd_pending = 1'b0;
      end
      if (!active) halted = 1'b1;
      else begin
        waitrequest = (stall_left > 0) && (stall_on || (read && address == stall_addr));
        if (waitrequest) begin
          if (stall_on) begin
            check("stall_address", address, stall_addr);
            check("stall_read", {31'd0, read}, 32'd1);
          end
          stall_on = 1'b1;
          stall_left--;
          stall_seen++;
        end
        if (read && write) overlap = 1'b1;
        if (read && !waitrequest) begin
          rd_data    = mem_rd(address);
          rd_pending = 1'b1;
        end
        if (write && !waitrequest) begin
          check("wr_expected", 32'(exp_wr_q.size() > 0), 32'd1);
          if (exp_wr_q.size() > 0) begin
            w = exp_wr_q.pop_front();
            check("wr_addr", address, w.addr);
            check("wr_data", writedata, w.data);
            check("wr_be", {28'd0, byteenable}, {28'd0, w.be});
          end
          if (address[31:16] != 16'hBFC0)
            for (int b = 0; b < 4; b++)
              if (byteenable[b]) ram[address[7:2]][8*b +: 8] = writedata[8*b +: 8];
        end
      end
      if (!halted) begin
        @(negedge clk);
        #1;
      end
    end
    waitrequest = 1'b0;
    check("halted_in_budget", {31'd0, halted}, 32'd1);
    check("active_low", {31'd0, active}, 32'd0);
    check("rw_exclusive", {31'd0, overlap}, 32'd0);
    check("writes_drained", 32'(exp_wr_q.size()), 32'd0);
    if (exp_v0_q.size() > 0) check("register_v0", register_v0, exp_v0_q.pop_front());
  endtask

  task automatic load_bltz(input logic [31:0] word);
    clear_mem();
    rom[0]  = ity(6'h0F, 5'd0, 5'd8, 16'hBFC0);
    rom[1]  = ity(6'h23, 5'd8, 5'd9, 16'h002C);
    rom[2]  = ity(6'h01, 5'd9, 5'd0, 16'd3);
    rom[3]  = NOP;
    rom[4]  = JR0;
    rom[5]  = NOP;
    rom[6]  = ity(6'h0F, 5'd0, 5'd2, 16'hFFFF);
    rom[7]  = JR0;
    rom[8]  = NOP;
    rom[11] = word;
    exp_v0_q.push_back(word[31] ? 32'hFFFF0000 : 32'h00000000);
  endtask

  task automatic load_swlw();
    clear_mem();
    rom[0] = ity(6'h09, 5'd0, 5'd3, 16'd15);
    rom[1] = ity(6'h2B, 5'd0, 5'd3, 16'h0010);
    rom[2] = ity(6'h23, 5'd0, 5'd2, 16'h0010);
    rom[3] = JR0;
    rom[4] = NOP;
    exp_store(32'h0000_0010, 32'd15);
    exp_v0_q.push_back(32'd15);
  endtask

  task automatic load_jal();
    logic [31:0] sub_addr;
    clear_mem();
    sub_addr = 32'hBFC00010;
    rom[0] = {6'h03, sub_addr[27:2]};
    rom[1] = NOP;
    rom[2] = JR0;
    rom[3] = NOP;
    rom[4] = rty(5'd31, 5'd0, 5'd2, 5'd0, 6'h21);
    rom[5] = JR0;
    rom[6] = NOP;
    exp_v0_q.push_back(32'hBFC00000 + 32'd8);
  endtask

  task automatic load_alu();
    clear_mem();
    rom[0]  = ity(6'h09, 5'd0, 5'd4, 16'hFFFD);
    rom[1]  = ity(6'h0D, 5'd0, 5'd5, 16'h8005);
    rom[2]  = rty(5'd4, 5'd5, 5'd6, 5'd0, 6'h23);
    rom[3]  = ity(6'h2B, 5'd0, 5'd6, 16'h0020);
    rom[4]  = rty(5'd4, 5'd5, 5'd7, 5'd0, 6'h2A);
    rom[5]  = rty(5'd4, 5'd5, 5'd8, 5'd0, 6'h2B);
    rom[6]  = rty(5'd0, 5'd7, 5'd9, 5'd5, 6'h00);
    rom[7]  = rty(5'd9, 5'd8, 5'd9, 5'd0, 6'h25);
    rom[8]  = ity(6'h2B, 5'd0, 5'd9, 16'h0024);
    rom[9]  = rty(5'd0, 5'd4, 5'd10, 5'd1, 6'h03);
    rom[10] = rty(5'd0, 5'd4, 5'd11, 5'd28, 6'h02);
    rom[11] = rty(5'd10, 5'd11, 5'd12, 5'd0, 6'h26);
    rom[12] = ity(6'h2B, 5'd0, 5'd12, 16'h0028);
    rom[13] = ity(6'h0C, 5'd4, 5'd13, 16'hFFF0);
    rom[14] = rty(5'd13, 5'd0, 5'd14, 5'd0, 6'h27);
    rom[15] = ity(6'h2B, 5'd0, 5'd14, 16'h002C);
    rom[16] = ity(6'h0A, 5'd4, 5'd15, 16'hFFFE);
    rom[17] = ity(6'h0B, 5'd5, 5'd16, 16'hFFFF);
    rom[18] = rty(5'd15, 5'd16, 5'd17, 5'd0, 6'h21);
    rom[19] = rty(5'd7, 5'd17, 5'd18, 5'd0, 6'h04);
    rom[20] = rty(5'd17, 5'd4, 5'd20, 5'd0, 6'h06);
    rom[21] = rty(5'd18, 5'd20, 5'd21, 5'd0, 6'h21);
    rom[22] = ity(6'h2B, 5'd0, 5'd21, 16'h0030);
    rom[23] = rty(5'd17, 5'd4, 5'd22, 5'd0, 6'h07);
    rom[24] = ity(6'h0E, 5'd22, 5'd23, 16'h1234);
    rom[25] = ity(6'h2B, 5'd0, 5'd23, 16'h0034);
    rom[26] = ity(6'h05, 5'd7, 5'd0, 16'd3);
    rom[27] = ity(6'h09, 5'd0, 5'd2, 16'd7);
    rom[28] = ity(6'h09, 5'd2, 5'd2, 16'd100);
    rom[29] = NOP;
    rom[30] = ity(6'h01, 5'd4, 5'h11, 16'd5);
    rom[31] = ity(6'h09, 5'd2, 5'd2, 16'd1);
    rom[32] = ity(6'h2B, 5'd0, 5'd31, 16'h0038);
    rom[33] = JR0;
    rom[34] = NOP;
    exp_store(32'h20, 32'hFFFF7FF8);
    exp_store(32'h24, 32'h00000020);
    exp_store(32'h28, 32'hFFFFFFF1);
    exp_store(32'h2C, 32'hFFFF000F);
    exp_store(32'h30, 32'h40000003);
    exp_store(32'h34, 32'hFFFFEDCB);
    exp_store(32'h38, 32'hBFC00080);
    exp_v0_q.push_back(32'd8);
  endtask

  initial begin
    load_bltz(32'h00000000);
    apply_reset(1'b1);
    run_prog(2000);

    load_bltz(32'hFFFFFFF1);
    apply_reset(1'b0);
    run_prog(2000);

    load_bltz(32'hFFFFFFF1);
    stall_addr = 32'hBFC00008;
    stall_len  = 5;
    apply_reset(1'b0);
    run_prog(2000);
    check("stall_cycles", 32'(stall_seen), 32'd5);
    stall_len = 0;

    load_swlw();
    apply_reset(1'b0);
    run_prog(2000);

    load_jal();
    apply_reset(1'b0);
    run_prog(2000);

    load_alu();
    apply_reset(1'b0);
    run_prog(4000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
